instr_mem_port_arb: RTL and testbench

// Arbiter and protocol adapter in front of the instruction RAM/boot ROM wrapper.

---
 rtl/instr_mem_port_arb_if.sv | 54 +++++
 rtl/instr_mem_port_arb.sv | 105 ++++++++++
 tb/tb_instr_mem_port_arb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_port_arb_if.sv
// Bundle between the instruction-memory arbiter, its two requesters and the RAM/ROM wrapper.
// Handshake: a request is accepted on any cycle where req and gnt are both high; its rvalid follows exactly one cycle later.
interface instr_mem_port_arb_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  core_req_i;
    logic [31:0]           core_addr_i;
    logic                  core_gnt_o;
    logic                  core_rvalid_o;
    logic [DATA_WIDTH-1:0] core_rdata_o;

    logic                  ld_req_i;
    logic                  ld_we_i;
    logic [31:0]           ld_addr_i;
    logic [DATA_WIDTH-1:0] ld_wdata_i;
    logic [BE_WIDTH-1:0]   ld_be_i;
    logic                  ld_gnt_o;
    logic                  ld_rvalid_o;
    logic [DATA_WIDTH-1:0] ld_rdata_o;
    logic                  ld_lock_i;
    logic [15:0]           ld_word_cnt_o;

    logic                  mem_en_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_we_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic [1:0]            owner_dbg_o;

    modport slave (
        input  core_req_i, core_addr_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o,
        input  ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_be_i, ld_lock_i,
        output ld_gnt_o, ld_rvalid_o, ld_rdata_o, ld_word_cnt_o,
        output mem_en_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
        input  mem_rdata_i,
        output owner_dbg_o
    );

    modport master (
        output core_req_i, core_addr_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o,
        output ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_be_i, ld_lock_i,
        input  ld_gnt_o, ld_rvalid_o, ld_rdata_o, ld_word_cnt_o,
        input  mem_en_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
        output mem_rdata_i,
        input  owner_dbg_o
    );
endinterface

// File: rtl/instr_mem_port_arb.sv
// Merges core instruction fetch and program-loader traffic onto one 1-cycle-latency memory port,
// with a starvation guard for the core and a load-lock mode that counts loader writes.
module instr_mem_port_arb #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    instr_mem_port_arb_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

    owner_e        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          lock_q, lock_d;
    logic [15:0]   word_cnt_q, word_cnt_d;

    logic core_ok, core_turn, core_gnt, ld_gnt;
    logic unused_addr_bits;

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        core_ok   = rst_n & bus.core_req_i & ~bus.ld_lock_i;
        core_turn = core_ok & (starve_q == STARVE_LIM);
        ld_gnt    = rst_n & bus.ld_req_i & ~core_turn;
        core_gnt  = core_ok & ~ld_gnt;
    end

    always_comb begin
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = '0;
        if (ld_gnt) begin
            bus.mem_addr_o  = bus.ld_addr_i[ADDR_WIDTH-1:0];
            bus.mem_wdata_o = bus.ld_wdata_i;
            bus.mem_we_o    = bus.ld_we_i;
            bus.mem_be_o    = bus.ld_be_i;
        end else if (core_gnt) begin
            bus.mem_addr_o = bus.core_addr_i[ADDR_WIDTH-1:0];
            bus.mem_be_o   = '1;
        end
    end

    always_comb begin
        owner_d    = OWN_NONE;
        starve_d   = starve_q;
        lock_d     = bus.ld_lock_i;
        word_cnt_d = word_cnt_q;

        if (ld_gnt) begin
            owner_d = OWN_LD;
        end else if (core_gnt) begin
            owner_d = OWN_CORE;
        end

        // Only loader wins taken while the core is actually waiting count toward starvation.
        if (!bus.core_req_i || core_gnt) begin
            starve_d = '0;
        end else if (ld_gnt && core_ok && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end

        if (bus.ld_lock_i && !lock_q) begin
            word_cnt_d = '0;
        end else if (ld_gnt && bus.ld_we_i) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            starve_q   <= '0;
            lock_q     <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            lock_q     <= lock_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign bus.core_gnt_o    = core_gnt;
    assign bus.ld_gnt_o      = ld_gnt;
    assign bus.mem_en_o      = core_gnt | ld_gnt;
    assign bus.core_rvalid_o = (owner_q == OWN_CORE);
    assign bus.ld_rvalid_o   = (owner_q == OWN_LD);
    assign bus.core_rdata_o  = (owner_q == OWN_CORE) ? bus.mem_rdata_i : '0;
    assign bus.ld_rdata_o    = (owner_q == OWN_LD) ? bus.mem_rdata_i : '0;
    assign bus.ld_word_cnt_o = word_cnt_q;
    assign bus.owner_dbg_o   = owner_q;

    // Address bits above the memory window are deliberately ignored.
    assign unused_addr_bits = ^{bus.core_addr_i[31:ADDR_WIDTH], bus.ld_addr_i[31:ADDR_WIDTH]};
endmodule

// File: tb/tb_instr_mem_port_arb.sv
// Randomized and directed bench for instr_mem_port_arb: a cycle model predicts grants and
// pushes expected responses; a separate monitor pops them when rvalid is due.
module tb_instr_mem_port_arb;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int EW   = 50;  // {cyc[15:0], is_ld, is_wr, data[31:0]}

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_mem_port_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    instr_mem_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(SMAX)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_errs = 0;
    int unsigned cyc = 0;
    logic [EW-1:0] exp_q[$];

    int          m_streak = 0;
    logic        m_lock_prev = 1'b0;
    logic [15:0] m_cnt = 16'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [15:0] a);
        if (a == 16'h0080) return 32'hDEADBEEF;
        return {~a, a} ^ 32'h5A5A_0000;
    endfunction

    // ---------------- clock/reset and memory environment ----------------
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        logic        en;
        logic [15:0] a;
        bus.mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            en = bus.mem_en_o;
            a  = bus.mem_addr_o;
            #2;
            bus.mem_rdata_i = en ? mem_fn(a) : $urandom;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic creq, input logic [31:0] caddr, input logic lreq,
                         input logic lwe, input logic [31:0] laddr, input logic [31:0] lwd,
                         input logic [3:0] lbe, input logic lock);
        @(posedge clk);
        #1;
        bus.core_req_i  = creq;
        bus.core_addr_i = caddr;
        bus.ld_req_i    = lreq;
        bus.ld_we_i     = lwe;
        bus.ld_addr_i   = laddr;
        bus.ld_wdata_i  = lwd;
        bus.ld_be_i     = lbe;
        bus.ld_lock_i   = lock;
    endtask

    task automatic idle(input logic creq, input logic lock);
        drive(creq, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, lock);
    endtask

    // ---------------- reference model: grant prediction ----------------
    always @(negedge clk) begin
        logic        core_el, e_core, e_ld;
        logic [52:0] e_bus;
        if (!rst_n) begin
            check("rst_ctrl", {bus.core_gnt_o, bus.core_rvalid_o, bus.ld_gnt_o, bus.ld_rvalid_o, bus.mem_en_o}, 0);
            check("rst_rdata", {bus.core_rdata_o, bus.ld_rdata_o}, 0);
            check("rst_mem", {bus.mem_addr_o, bus.mem_wdata_o, bus.mem_we_o, bus.mem_be_o}, 0);
            check("rst_cnt", bus.ld_word_cnt_o, 0);
            m_streak    = 0;
            m_lock_prev = 1'b0;
            m_cnt       = 16'd0;
        end else begin
            core_el = bus.core_req_i && !bus.ld_lock_i;
            e_ld    = bus.ld_req_i && !(core_el && m_streak == SMAX);
            e_core  = core_el && !e_ld;
            if (e_ld)
                e_bus = {bus.ld_addr_i[15:0], bus.ld_wdata_i, bus.ld_we_i, bus.ld_be_i};
            else if (e_core)
                e_bus = {bus.core_addr_i[15:0], 32'h0, 1'b0, 4'hF};
            else
                e_bus = '0;

            check("core_gnt", bus.core_gnt_o, e_core);
            check("ld_gnt", bus.ld_gnt_o, e_ld);
            check("mem_en", bus.mem_en_o, e_core | e_ld);
            check("mem_bus", {bus.mem_addr_o, bus.mem_wdata_o, bus.mem_we_o, bus.mem_be_o}, e_bus);
            check("word_cnt", bus.ld_word_cnt_o, m_cnt);

            if (e_ld)
                exp_q.push_back({16'(cyc + 1), 1'b1, bus.ld_we_i,
                                 bus.ld_we_i ? 32'h0 : mem_fn(bus.ld_addr_i[15:0])});
            else if (e_core)
                exp_q.push_back({16'(cyc + 1), 1'b0, 1'b0, mem_fn(bus.core_addr_i[15:0])});

            if (!bus.core_req_i || e_core) m_streak = 0;
            else if (e_ld && core_el && m_streak < SMAX) m_streak++;

            if (bus.ld_lock_i && !m_lock_prev) m_cnt = 16'd0;
            else if (e_ld && bus.ld_we_i) m_cnt = m_cnt + 16'd1;
            m_lock_prev = bus.ld_lock_i;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else if (exp_q.size() > 0 && exp_q[0][49:34] == cyc[15:0]) begin
            e = exp_q.pop_front();
            check("rvalid_route", {bus.core_rvalid_o, bus.ld_rvalid_o}, {!e[33], e[33]});
            if (e[33]) begin
                if (!e[32]) check("ld_rdata", bus.ld_rdata_o, e[31:0]);
                check("core_rdata_quiet", bus.core_rdata_o, 0);
            end else begin
                check("core_rdata", bus.core_rdata_o, e[31:0]);
                check("ld_rdata_quiet", bus.ld_rdata_o, 0);
            end
        end else begin
            check("idle_rvalid", {bus.core_rvalid_o, bus.ld_rvalid_o}, 0);
            check("idle_rdata", {bus.core_rdata_o, bus.ld_rdata_o}, 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int   n_core;
        logic lock;
        bus.core_req_i  = 1'b0;
        bus.core_addr_i = '0;
        bus.ld_req_i    = 1'b0;
        bus.ld_we_i     = 1'b0;
        bus.ld_addr_i   = '0;
        bus.ld_wdata_i  = '0;
        bus.ld_be_i     = '0;
        bus.ld_lock_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // core-only fetch
        drive(1'b1, 32'h0000_0080, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        check("core_only_gnt", bus.core_gnt_o, 1);
        idle(1'b0, 1'b0);
        @(negedge clk);
        check("core_only_rvalid", bus.core_rvalid_o, 1);
        check("core_only_rdata", bus.core_rdata_o, 32'hDEADBEEF);

        // both requesting every cycle: 4 loader grants then 1 core grant
        n_core = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'h0, 4'hF, 1'b0);
            @(negedge clk);
            if (bus.core_gnt_o) n_core++;
        end
        check("starve_pattern_core_grants", n_core, 2);

        // load lock: core held off, four writes counted from the lock rise
        idle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 32'h40, 1'b1, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 1'b1);
        idle(1'b1, 1'b1);
        @(negedge clk);
        check("lock_cnt4", bus.ld_word_cnt_o, 4);
        check("lock_core_held", bus.core_gnt_o, 0);

        // lock re-rise coinciding with a write: cleared, write not counted
        idle(1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h1111_1111, 4'hF, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 32'h2222_2222, 4'hF, 1'b1);
        @(negedge clk);
        check("lock_edge_clear", bus.ld_word_cnt_o, 0);
        idle(1'b0, 1'b1);
        @(negedge clk);
        check("lock_next_write", bus.ld_word_cnt_o, 1);

        // boot ROM select bit passes through on the memory address
        drive(1'b1, 32'h0000_8004, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        check("boot_rom_addr", bus.mem_addr_o, 16'h8004);

        // reset right after a loader read grant discards its response
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_0040, 32'h0, 4'hF, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        bus.ld_req_i = 1'b0;
        @(negedge clk);
        check("reset_drops_ld_rvalid", bus.ld_rvalid_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // randomized traffic with occasional lock toggles and resets
        lock = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) lock = ~lock;
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom_range(0, 15)), lock);
            rst_n = ($urandom_range(0, 499) != 0);
        end
        rst_n = 1'b1;
        repeat (3) idle(1'b0, 1'b0);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
